// File: rtl/tt_sweep_controller.sv
// Truth-table sweep sequencer for a 3-input gate. It steps through all eight
// input combinations, samples the gate after a settle interval, and scores the table.
module tt_sweep_controller #(
  parameter logic [7:0] EXPECTED      = 8'hD5,
  parameter int         SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic [2:0] dut_in,
  output logic       busy,
  output logic       done,
  output logic       results_valid,
  output logic [7:0] measured,
  output logic [7:0] mismatch_mask,
  output logic [3:0] mismatch_count,
  output logic       pass
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("tt_sweep_controller: SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic [7:0] shadow;
  logic [7:0] diff;
  logic [3:0] diff_count;

  assign diff   = shadow ^ EXPECTED;
  assign dut_in = idx;

  always_comb begin
    diff_count = '0;
    for (int i = 0; i < 8; i++) begin
      diff_count = diff_count + 4'(diff[i]);
    end
  end

  // idx returns to 0 whenever no sweep is running, so it doubles as the gate drive
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      shadow         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      results_valid  <= 1'b0;
      measured       <= '0;
      mismatch_mask  <= '0;
      mismatch_count <= '0;
      pass           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state  <= APPLY;
            idx    <= '0;
            cnt    <= '0;
            shadow <= '0;
            busy   <= 1'b1;
          end
        end
        APPLY: begin
          if (abort) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt == LAST_CNT) begin
              state <= SAMPLE;
            end
          end
        end
        SAMPLE: begin
          if (abort) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            shadow[3'd7 - idx] <= dut_out;
            if (idx == 3'd7) begin
              state <= DONE;
              idx   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= APPLY;
              idx   <= idx + 3'd1;
              cnt   <= '0;
            end
          end
        end
        DONE: begin
          measured       <= shadow;
          mismatch_mask  <= diff;
          mismatch_count <= diff_count;
          pass           <= (diff_count == 4'd0);
          results_valid  <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_controller.sv
// Bench for tt_sweep_controller: two instances (settle 4 and settle 2) share stimulus
// and drive behavioural gate models; commits are predicted from the sweep timing rules.
module tb_tt_sweep_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [1:0] dout;
  logic [2:0] din [2];
  logic [1:0] busy;
  logic [1:0] done;
  logic [1:0] valid;
  logic [7:0] meas [2];
  logic [7:0] mask [2];
  logic [3:0] mcount [2];
  logic [1:0] pass;

  // gate_mode: 0 = ideal table, 1 = stuck at stuck_val, 2 = table with 3-cycle delay
  int         gate_mode = 0;
  logic [7:0] gate_tbl  = 8'hD5;
  logic       stuck_val = 1'b0;
  logic [2:0] h1 [2] = '{3'd0, 3'd0};
  logic [2:0] h2 [2] = '{3'd0, 3'd0};
  logic [2:0] h3 [2] = '{3'd0, 3'd0};

  logic [7:0] exp_meas  [2] = '{8'h00, 8'h00};
  bit         exp_valid [2] = '{1'b0, 1'b0};
  int         settle    [2] = '{4, 2};

  int checks   = 0;
  int failures = 0;

  tt_sweep_controller u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_out(dout[0]),
    .dut_in(din[0]), .busy(busy[0]), .done(done[0]), .results_valid(valid[0]),
    .measured(meas[0]), .mismatch_mask(mask[0]), .mismatch_count(mcount[0]), .pass(pass[0])
  );

  tt_sweep_controller #(.EXPECTED(8'hD5), .SETTLE_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_out(dout[1]),
    .dut_in(din[1]), .busy(busy[1]), .done(done[1]), .results_valid(valid[1]),
    .measured(meas[1]), .mismatch_mask(mask[1]), .mismatch_count(mcount[1]), .pass(pass[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      h3[i] <= h2[i];
      h2[i] <= h1[i];
      h1[i] <= din[i];
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < 2; i++) begin
      case (gate_mode)
        0:       dout[i] = gate_tbl[3'd7 - din[i]];
        1:       dout[i] = stuck_val;
        default: dout[i] = gate_tbl[3'd7 - h3[i]];
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // The sample for combination k is the gate output seen settle cycles after k is
  // applied; a 3-cycle gate delay longer than that shows the previous combination.
  function automatic logic [7:0] predict(input int s);
    logic [7:0] m;
    int src;
    m = '0;
    for (int k = 0; k < 8; k++) begin
      src = (gate_mode == 2 && s < 3) ? ((k > 0) ? k - 1 : 0) : k;
      m[7 - k] = (gate_mode == 1) ? stuck_val : gate_tbl[7 - src];
    end
    return m;
  endfunction

  task automatic checkCommitted(input string tag);
    logic [7:0] em;
    for (int i = 0; i < 2; i++) begin
      em = exp_valid[i] ? (exp_meas[i] ^ 8'hD5) : 8'h00;
      checkOutput($sformatf("%s_meas%0d", tag, i), meas[i], exp_meas[i]);
      checkOutput($sformatf("%s_mask%0d", tag, i), mask[i], em);
      checkOutput($sformatf("%s_count%0d", tag, i), 8'(mcount[i]), 8'($countones(em)));
      checkOutput($sformatf("%s_valid%0d", tag, i), 8'(valid[i]), 8'(exp_valid[i]));
      checkOutput($sformatf("%s_pass%0d", tag, i), 8'(pass[i]), 8'(exp_valid[i] && em == 8'h00));
    end
  endtask

  task automatic checkIdle(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s_busy%0d", tag, i), 8'(busy[i]), 8'h00);
      checkOutput($sformatf("%s_done%0d", tag, i), 8'(done[i]), 8'h00);
      checkOutput($sformatf("%s_din%0d", tag, i), 8'(din[i]), 8'h00);
    end
  endtask

  // One start pulse, then 44 observed cycles; abort_at/restart_at (0 = none) raise
  // abort or start for the whole of that cycle.
  task automatic applyStimulus(input string tag, input int abort_at, input int restart_at);
    int   per;
    bit   aborted [2];
    logic eb, ed;
    logic [2:0] ei;
    for (int i = 0; i < 2; i++) begin
      per = settle[i] + 1;
      aborted[i] = (abort_at >= 1 && abort_at <= 8 * per);
    end
    start = 1'b1;
    abort = 1'b0;
    for (int c = 1; c <= 44; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < 2; i++) begin
        per = settle[i] + 1;
        eb = 1'b0; ed = 1'b0; ei = 3'd0;
        if (!(aborted[i] && c > abort_at)) begin
          if (c <= 8 * per) begin
            eb = 1'b1;
            ei = 3'((c - 1) / per);
          end else if (c == 8 * per + 1) begin
            ed = 1'b1;
          end
        end
        checkOutput($sformatf("%s_c%0d_busy%0d", tag, c, i), 8'(busy[i]), 8'(eb));
        checkOutput($sformatf("%s_c%0d_done%0d", tag, c, i), 8'(done[i]), 8'(ed));
        checkOutput($sformatf("%s_c%0d_din%0d", tag, c, i), 8'(din[i]), 8'(ei));
      end
      if (c == abort_at) abort = 1'b1;
      if (c == restart_at) start = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (!aborted[i]) begin
        exp_meas[i]  = predict(settle[i]);
        exp_valid[i] = 1'b1;
      end
    end
    checkCommitted(tag);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkIdle("reset");
    checkCommitted("reset");

    gate_mode = 0; gate_tbl = 8'hD5;
    applyStimulus("good", 0, 0);
    gate_tbl = 8'h2A;
    applyStimulus("inverted", 0, 0);
    gate_mode = 1; stuck_val = 1'b1;
    applyStimulus("stuck1", 0, 0);
    gate_mode = 2; gate_tbl = 8'hD5;
    applyStimulus("delay3", 0, 0);

    gate_mode = 0; gate_tbl = 8'hD5;
    applyStimulus("pre_abort", 0, 0);
    gate_mode = 1; stuck_val = 1'b0;
    applyStimulus("abort_idx3", 16, 0);
    applyStimulus("after_abort", 0, 0);

    gate_mode = 0; gate_tbl = 8'hD5;
    applyStimulus("restart_busy", 0, 10);

    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkIdle($sformatf("start_abort_idle%0d", c));
      @(posedge clk); #1;
    end
    checkCommitted("start_abort_idle");

    for (int n = 0; n < 12; n++) begin
      int ab, rs;
      gate_mode = $urandom_range(0, 2);
      gate_tbl  = 8'($urandom);
      stuck_val = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 44) : 0;
      rs = (ab == 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
      applyStimulus($sformatf("rand%0d", n), ab, rs);
    end

    gate_mode = 0; gate_tbl = 8'hD5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_meas  = '{8'h00, 8'h00};
    exp_valid = '{1'b0, 1'b0};
    checkIdle("mid_reset");
    checkCommitted("mid_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
